muldiv_sequencer: RTL

Multi-cycle sequencer for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in the EX stage. It accepts one M-extension operation, performs XLEN-step iterative shift-add multiply or restoring divide, and stalls the pipeline until the result is ready. Decode raises start when an R-type instruction has Funct7 = 0000001; the main ALU result is bypassed while the sequencer owns the stage.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_datapath.sv | 71 +++++++
 rtl/muldiv_sequencer.sv | 60 ++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared FSM state, RV32M funct3 codes and operand-signedness helpers
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction
  function automatic logic signed_a(input logic [2:0] f);
    return f == F3_MULH || f == F3_MULHSU || f == F3_DIV || f == F3_REM;
  endfunction
  function automatic logic signed_b(input logic [2:0] f);
    return f == F3_MULH || f == F3_DIV || f == F3_REM;
  endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared product/remainder-quotient register with shift-add and restoring-divide step
// Ports: clk_i/reset_i clock and async reset; load_i latches operands, step_i runs one
// iteration, finish_i registers result_o (from the stepped value when step_i, else the
// special divide result); special_o flags divide-by-zero / signed overflow on the inputs.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            finish_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            special_o,
  output logic [XLEN-1:0] result_o
);
  // acc holds {hi, lo}: product for multiply, {remainder, quotient} for divide
  logic [2*XLEN-1:0] acc_q, acc_s, acc_mul, acc_div, prod;
  logic [XLEN-1:0]   m_q, abs_a, abs_b, val, fin, spec_res, diff;
  logic [XLEN:0]     sum, shl;
  logic [2:0]        f_q;
  logic              neg_q, neg_d, sa_neg, sb_neg, div0, ovf, ge;
  always_comb begin
    sa_neg    = signed_a(funct3_i) && op_a_i[XLEN-1];
    sb_neg    = signed_b(funct3_i) && op_b_i[XLEN-1];
    abs_a     = sa_neg ? -op_a_i : op_a_i;
    abs_b     = sb_neg ? -op_b_i : op_b_i;
    // remainder sign follows the dividend; everything else is the product of signs
    neg_d     = (is_div(funct3_i) && funct3_i[1]) ? sa_neg : sa_neg ^ sb_neg;
    div0      = is_div(funct3_i) && op_b_i == '0;
    ovf       = is_div(funct3_i) && signed_a(funct3_i) &&
                op_a_i == {1'b1, {(XLEN-1){1'b0}}} && op_b_i == '1;
    special_o = div0 || ovf;
    // overflow quotient equals op_a (the most negative value), so op_a serves both cases
    spec_res  = funct3_i[1] ? (div0 ? op_a_i : '0) : (div0 ? '1 : op_a_i);
    sum       = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, m_q};
    acc_mul   = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    shl       = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge        = shl >= {1'b0, m_q};
    diff      = shl[XLEN-1:0] - m_q;
    acc_div   = {ge ? diff : shl[XLEN-1:0], acc_q[XLEN-2:0], ge};
    acc_s     = is_div(f_q) ? acc_div : acc_mul;
    prod      = neg_q ? -acc_s : acc_s;
    val       = f_q[1] ? acc_s[2*XLEN-1:XLEN] : acc_s[XLEN-1:0];
    fin       = is_div(f_q) ? (neg_q ? -val : val) :
                (f_q == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q    <= '0;
      m_q      <= '0;
      f_q      <= '0;
      neg_q    <= 1'b0;
      result_o <= '0;
    end else begin
      if (load_i) begin
        acc_q <= {{XLEN{1'b0}}, is_div(funct3_i) ? abs_a : abs_b};
        m_q   <= is_div(funct3_i) ? abs_b : abs_a;
        f_q   <= funct3_i;
        neg_q <= neg_d;
      end else if (step_i) begin
        acc_q <= acc_s;
      end
      if (finish_i) result_o <= step_i ? fin : spec_res;
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide sequencer that stalls the EX stage
// Ports: clk_i clock, reset_i async active-high reset; start_i request (taken in IDLE),
// flush_i kills the operation; funct3_i/op_a_i/op_b_i operation; busy_o = CALC|DONE,
// stall_o holds the pipeline, done_o one-cycle result-valid pulse, result_o held result.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CNT_W = $clog2(XLEN);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, special, go, last, load, step, finish;
  always_comb begin
    go     = state_q == IDLE && start_i && !flush_i;
    step   = state_q == CALC && !flush_i;
    last   = step && cnt_q == '0;
    load   = go && !special;
    // special divides resolve at the start edge; normal ops finish on the last iteration
    finish = (go && special) || last;
  end
  assign busy_o  = state_q != IDLE;
  assign stall_o = go || state_q == CALC;
  assign done_o  = done_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= finish;
      state_q <= finish ? DONE : (load || (step && !last)) ? CALC : IDLE;
      cnt_q   <= load ? CNT_W'(XLEN-1) : (step && !last) ? cnt_q - CNT_W'(1) : cnt_q;
    end
  end
  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (load),
    .step_i   (step),
    .finish_i (finish),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .special_o(special),
    .result_o (result_o)
  );
endmodule
